// File: rtl/stream_fifo_share_arb.sv
// Round-robin arbiter feeding a shared FIFO, with per-requester occupancy quotas.
// Optional burst locking is compiled in with STREAM_FIFO_SHARE_ARB_LOCK_EN.
module stream_fifo_share_arb #(
   parameter int N_REQ      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int QUOTA      = 4,
   localparam int IDX_WIDTH = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CNT_WIDTH = $clog2(QUOTA + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]   data_i,
   input  logic [N_REQ-1:0]              valid_i,
   input  logic [N_REQ-1:0]              last_i,
   output logic [N_REQ-1:0]              ready_o,
   output logic [DATA_WIDTH-1:0]         data_o,
   output logic [IDX_WIDTH-1:0]          id_o,
   output logic                          last_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   input  logic                          release_i,
   input  logic [IDX_WIDTH-1:0]          release_id_i,
   output logic [N_REQ*CNT_WIDTH-1:0]    occupancy_o,
   output logic                          release_err_o
);

   logic [CNT_WIDTH-1:0]                occ_q [N_REQ];
   logic [IDX_WIDTH-1:0]                rr_ptr_q;
   logic                                hold_q;
   logic [IDX_WIDTH-1:0]                hold_id_q;
   logic                                release_err_q;
`ifdef STREAM_FIFO_SHARE_ARB_LOCK_EN
   logic                                lock_q;
   logic [IDX_WIDTH-1:0]                lock_id_q;
`endif

   logic [N_REQ-1:0]                    elig;
   logic [N_REQ-1:0]                    rel_dec;
   logic                                rel_err;
   logic                                pick_found;
   logic [IDX_WIDTH-1:0]                pick_idx;
   logic                                gnt_vld;
   logic [IDX_WIDTH-1:0]                gnt_idx;
   logic                                xfer;
   logic [N_REQ-1:0][DATA_WIDTH-1:0]    data_v;

   assign data_v = data_i;

   // Eligibility only looks at registered occupancy; a same-cycle release does not count.
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         elig[k]    = valid_i[k] && (occ_q[k] < CNT_WIDTH'(QUOTA));
         rel_dec[k] = release_i && (release_id_i == IDX_WIDTH'(k)) && (occ_q[k] != '0);
      end
      rel_err = release_i && (rel_dec == '0);
   end

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         int j;
         j = int'(rr_ptr_q) + i;
         if (j >= N_REQ) j = j - N_REQ;
         if (!pick_found && elig[j]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_WIDTH'(j);
         end
      end
   end

   always_comb begin
      gnt_vld = pick_found;
      gnt_idx = pick_idx;
`ifdef STREAM_FIFO_SHARE_ARB_LOCK_EN
      if (lock_q) begin
         gnt_idx = lock_id_q;
         gnt_vld = elig[lock_id_q];
      end
`endif
      if (hold_q) begin
         gnt_idx = hold_id_q;
         gnt_vld = 1'b1;
      end
      if (rst_i || flush_i) gnt_vld = 1'b0;
   end

   assign xfer    = gnt_vld && ready_i;
   assign valid_o = gnt_vld;
   assign id_o    = gnt_idx;
   assign data_o  = data_v[gnt_idx];
   assign last_o  = last_i[gnt_idx];
   assign ready_o = xfer ? (N_REQ'(1) << gnt_idx) : '0;
   assign release_err_o = release_err_q;

   for (genvar k = 0; k < N_REQ; k++) begin : g_occ
      assign occupancy_o[k*CNT_WIDTH +: CNT_WIDTH] = occ_q[k];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         for (int k = 0; k < N_REQ; k++) occ_q[k] <= '0;
         rr_ptr_q      <= '0;
         hold_q        <= 1'b0;
         hold_id_q     <= '0;
         release_err_q <= 1'b0;
`ifdef STREAM_FIFO_SHARE_ARB_LOCK_EN
         lock_q        <= 1'b0;
         lock_id_q     <= '0;
`endif
      end else begin
         // A transfer and a valid release on the same index cancel out.
         for (int k = 0; k < N_REQ; k++) begin
            case ({xfer && (gnt_idx == IDX_WIDTH'(k)), rel_dec[k]})
               2'b10:   occ_q[k] <= occ_q[k] + CNT_WIDTH'(1);
               2'b01:   occ_q[k] <= occ_q[k] - CNT_WIDTH'(1);
               default: occ_q[k] <= occ_q[k];
            endcase
         end
         if (xfer)
            rr_ptr_q <= (gnt_idx == IDX_WIDTH'(N_REQ-1)) ? '0 : gnt_idx + IDX_WIDTH'(1);
         hold_q        <= gnt_vld && !ready_i;
         hold_id_q     <= gnt_idx;
         release_err_q <= rel_err;
`ifdef STREAM_FIFO_SHARE_ARB_LOCK_EN
         if (xfer) begin
            lock_q    <= !last_o;
            lock_id_q <= gnt_idx;
         end
`endif
      end
   end

endmodule

// File: tb/tb_stream_fifo_share_arb.sv
// Directed bench for stream_fifo_share_arb: expected grant order queued at stimulus time,
// popped and checked on each observed transfer.
module tb_stream_fifo_share_arb;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int Q  = 4;
   localparam int IW = 2;
   localparam int CW = 3;

   logic            clk_i = 1'b0;
   logic            rst_i, flush_i, ready_i, release_i;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    valid_i, last_i, ready_o;
   logic [DW-1:0]   data_o;
   logic [IW-1:0]   id_o, release_id_i;
   logic            last_o, valid_o, release_err_o;
   logic [N*CW-1:0] occupancy_o;

   stream_fifo_share_arb #(.N_REQ(N), .DATA_WIDTH(DW), .QUOTA(Q)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .data_i(data_i),
      .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o), .data_o(data_o),
      .id_o(id_o), .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i),
      .release_i(release_i), .release_id_i(release_id_i),
      .occupancy_o(occupancy_o), .release_err_o(release_err_o)
   );

   always #5 clk_i = ~clk_i;

   int chk = 0;
   int err = 0;
   int exp_q[$];
   int rem[N];
   bit alast[N];
   bit hold_chk;
   int hold_id;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      chk++;
      assert (act === exp) else begin
         err++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] occ(input int k);
      return occupancy_o[k*CW +: CW];
   endfunction

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         valid_i[k]          = rem[k] > 0;
         last_i[k]           = alast[k] || (rem[k] == 1);
         data_i[k*DW +: DW]  = {16'(k), 16'(rem[k])};
      end
   endtask

   // One cycle per iteration: drive, settle, check, then advance past the edge.
   task automatic run(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         int e;
         drive();
         #1;
         if (hold_chk) begin
            check("hold_valid", valid_o, 1);
            check("hold_id", id_o, hold_id);
            check("hold_data", data_o, {16'(hold_id), 16'(rem[hold_id])});
            check("hold_ready", ready_o, 0);
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) check("unexpected_xfer", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               check("xfer_id", id_o, e);
               check("xfer_data", data_o, {16'(e), 16'(rem[e])});
               check("xfer_ready", ready_o, N'(1) << e);
            end
         end
         for (int k = 0; k < N; k++) if (ready_o[k]) rem[k]--;
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic clr();
      for (int k = 0; k < N; k++) begin rem[k] = 0; alast[k] = 1'b1; end
   endtask

   task automatic do_flush();
      drive();
      flush_i = 1'b1;
      #1;
      check("flush_valid", valid_o, 0);
      check("flush_ready", ready_o, 0);
      @(posedge clk_i);
      #1;
      flush_i = 1'b0;
      for (int k = 0; k < N; k++) check("flush_occ", occ(k), 0);
   endtask

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1; release_i = 1'b0; release_id_i = '0;
      hold_chk = 1'b0; hold_id = 0;
      clr();
      for (int k = 0; k < N; k++) rem[k] = 1;
      drive();
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check("rst_valid", valid_o, 0);
      check("rst_ready", ready_o, 0);
      rst_i = 1'b0;
      clr();
      #1;
      check("rst_occ", occupancy_o, 0);
      check("rst_relerr", release_err_o, 0);

      // Three requesters until quota fills
      rem[0] = 100; rem[1] = 100; rem[2] = 100;
      for (int r = 0; r < 4; r++) begin exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); end
      run(14);
      drive(); #1;
      check("quota_valid", valid_o, 0);
      check("quota_occ", occupancy_o, {3'd0, 3'd4, 3'd4, 3'd4});
      check("quota_q", exp_q.size(), 0);
      do_flush();

      // Held grant to requester 1 under stall
      clr();
      rem[0] = 1; exp_q.push_back(0);
      run(2);
      rem[1] = 5; ready_i = 1'b0; hold_chk = 1'b1; hold_id = 1;
      run(1);
      rem[0] = 5;
      run(2);
      hold_chk = 1'b0; ready_i = 1'b1;
      exp_q.push_back(1);
      run(1);
      exp_q.push_back(0);
      run(1);
      check("hold_q", exp_q.size(), 0);
      clr();
      do_flush();

      // Transfer and release on the same index
      rem[2] = 2; exp_q.push_back(2); exp_q.push_back(2);
      run(3);
      rem[2] = 1; exp_q.push_back(2);
      release_i = 1'b1; release_id_i = 2'd2;
      run(1);
      release_i = 1'b0;
      check("same_occ2", occ(2), 2);
      check("same_relerr", release_err_o, 0);
      release_i = 1'b1; release_id_i = 2'd2;
      run(1);
      release_i = 1'b0;
      check("rel_occ2", occ(2), 1);
      check("rel_relerr", release_err_o, 0);
      release_i = 1'b1; release_id_i = 2'd3;
      run(1);
      release_i = 1'b0;
      check("under_relerr", release_err_o, 1);
      check("under_occ3", occ(3), 0);
      run(1);
      check("under_relerr_clr", release_err_o, 0);
      check("rel_q", exp_q.size(), 0);
      do_flush();

      // Burst from 0 while 1 (preloaded to occupancy 2) stays valid
      rem[1] = 2; exp_q.push_back(1); exp_q.push_back(1);
      run(3);
      alast[0] = 1'b0; alast[1] = 1'b0;
      rem[0] = 4; rem[1] = 100;
`ifdef STREAM_FIFO_SHARE_ARB_LOCK_EN
      foreach (exp_q[i]) ;
      exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
      exp_q.push_back(1); exp_q.push_back(1);
`else
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
      exp_q.push_back(0); exp_q.push_back(0);
`endif
      run(10);
      check("burst_q", exp_q.size(), 0);
      check("burst_occ0", occ(0), 4);
      check("burst_occ1", occ(1), 4);
      clr();
      do_flush();

      // Flush during held grant to requester 3, occupancy 1,2,0,3
      rem[0] = 1; rem[1] = 2; rem[3] = 3;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(3);
      run(8);
      check("pre_occ", occupancy_o, {3'd3, 3'd0, 3'd2, 3'd1});
      rem[3] = 1; ready_i = 1'b0; hold_chk = 1'b1; hold_id = 3;
      run(1);
      hold_chk = 1'b0;
      rem[0] = 1;
      do_flush();
      ready_i = 1'b1;
      exp_q.push_back(0); exp_q.push_back(3);
      run(3);
      check("restart_q", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end
endmodule

// File: doc/stream_fifo_share_arb.md
STREAM_FIFO_SHARE_ARB -- requirements
Module: stream_fifo_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2 to 16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: payload width per requester.
REQ-003 SHALL have parameter QUOTA, default 4: maximum shared-FIFO entries held per requester, 1 to 255.
REQ-004 SHALL have derived parameters IDX_WIDTH = max(1, clog2(N_REQ)) and CNT_WIDTH = clog2(QUOTA+1); these are not to be overridden.
REQ-005 SHALL have ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  clears all state
data_i  in  N_REQ*DATA_WIDTH  requester payloads, slice k belongs to requester k
valid_i  in  N_REQ  requester valid
last_i  in  N_REQ  requester end-of-burst flag
ready_o  out  N_REQ  requester accept
data_o  out  DATA_WIDTH  payload to shared FIFO
id_o  out  IDX_WIDTH  granted requester index
last_o  out  1  forwarded last flag
valid_o  out  1  shared-FIFO push valid
ready_i  in  1  shared-FIFO not full
release_i  in  1  consumer popped one entry
release_id_i  in  IDX_WIDTH  owner of the popped entry
occupancy_o  out  N_REQ*CNT_WIDTH  per-requester entries in flight
release_err_o  out  1  one-cycle pulse on release underflow

Function
REQ-006 SHALL treat requester k as eligible when valid_i[k]=1 and occ[k] < QUOTA; a release in the same cycle does not make it eligible.
REQ-007 SHALL, when no grant is held, pick the first eligible requester searching upward from rr_ptr and wrapping modulo N_REQ; arbitration is combinational, so valid_o asserts in the same cycle.
REQ-008 SHALL drive data_o, last_o and id_o from the granted slice, and drive valid_o=1 whenever a grant exists.
REQ-009 SHALL hold the grant when valid_o=1 and ready_i=0, keeping id_o and data_o stable regardless of other requesters; requesters must keep valid_i asserted once raised.
REQ-010 SHALL set ready_o[k] = (grant==k) & valid_o & ready_i; all other ready_o bits are 0.
REQ-011 SHALL, on transfer (valid_o & ready_i), increment occ[grant] and set rr_ptr to (grant+1) mod N_REQ.
REQ-012 SHALL, on release_i with occ[release_id_i] > 0, decrement that counter.
REQ-013 SHALL leave a counter unchanged when a transfer and a release hit the same index in the same cycle.
REQ-014 SHALL, on release_i with occ[release_id_i]=0 (or release_id_i >= N_REQ), ignore the release and pulse release_err_o for one cycle.
REQ-015 SHALL give flush_i priority over all other events: next cycle all occ=0, rr_ptr=0, hold and lock cleared; valid_o and ready_o are forced 0 during the flush cycle.
REQ-016 SHALL drive occupancy_o directly from registers.
REQ-017 SHALL size the downstream FIFO depth as at least N_REQ*QUOTA; with that sizing, ready_i=0 only under consumer stall.

Reset
REQ-018 SHALL, on rst_i=1 at a clock edge, set occ=0, rr_ptr=0, hold=0, lock=0 and release_err_o=0.
REQ-019 SHALL hold valid_o=0 and ready_o=0 during reset; reset asserted mid-burst or mid-hold discards the burst or hold with no partial transfer.

Configuration
REQ-020 SHALL support macro STREAM_FIFO_SHARE_ARB_LOCK_EN.
  - Defined: after a transfer with last=0, the grant locks to that requester until a beat with last=1 transfers, ignoring rr_ptr and other requesters. If that requester reaches QUOTA while locked, valid_o=0 until a release restores eligibility; the lock persists. flush_i and reset clear the lock.
  - Undefined: arbitration is per beat, last_i is only forwarded to last_o, and no lock register exists.

Verification
REQ-021 QUOTA=4; requesters 0,1,2 continuously valid; ready_i=1; no releases -> id_o sequence 0,1,2 repeated four times, then valid_o=0 with occupancy 4,4,4,0.
REQ-022 Grant to requester 1 with ready_i=0 for 3 cycles while requester 0 is valid -> id_o=1 and data stable for 3 cycles, then one transfer and ready_o[1] pulses once.
REQ-023 occ[2]=2; transfer from requester 2 and release_id_i=2 in the same cycle -> occ[2] stays 2 and release_err_o=0.
REQ-024 release_i with release_id_i=3 while occ[3]=0 -> release_err_o high for exactly one cycle and occ[3] stays 0.
REQ-025 Requester 0 sends a 4-beat burst (last on beat 4) while requester 1 is continuously valid -> with LOCK_EN: id_o 0,0,0,0,1; without LOCK_EN: id_o 0,1,0,1,0,0.
REQ-026 flush_i during a held grant to requester 3 with occupancy 1,2,0,3 -> next cycle all occupancy 0 and arbitration restarts from index 0.
